alu_serial_seq: RTL and testbench

//   Bit-serial sequencer that sits directly upstream and downstream of the 1-bit alu.
//   It accepts WIDTH-bit operands plus mode/opcode through a start/done handshake.
//   It presents operand bits LSB-first to the alu's ain/bin, one bit per clock.
//   It collects the alu's result and cout for each bit into WIDTH-bit output words.

---
 rtl/alu_serial_seq.sv | 139 +++++++++++++
 tb/tb_alu_serial_seq.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/alu_serial_seq.sv
// alu_serial_seq
//   Bit-serial sequencer wrapped around a 1-bit alu. An accepted start
//   latches WIDTH-bit operands plus mode/opcode. Operand bits are then fed
//   LSB-first to the alu, one per clock. The per-bit result/cout returned by
//   the alu are gathered into WIDTH-bit output words.
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   start                 request, sampled only in IDLE or DONE
//   mode_in, opcode_in    alu controls for the operation
//   a_in, b_in            operands, captured on an accepted start
//   busy                  high while bits are being shifted
//   done                  one-cycle pulse, result_out/cout_out valid
//   result_out, cout_out  bit i = alu result/cout for operand bit i
//   alu_mode, alu_opcode  alu controls (0 outside SHIFT)
//   alu_ain, alu_bin      current operand bits (0 outside SHIFT)
//   alu_result, alu_cout  combinational alu outputs for the current bit
module alu_serial_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode_in,
  input  logic [1:0]       opcode_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_out,
  output logic [WIDTH-1:0] cout_out,
  output logic [1:0]       alu_mode,
  output logic [1:0]       alu_opcode,
  output logic             alu_ain,
  output logic             alu_bin,
  input  logic             alu_result,
  input  logic             alu_cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic [WIDTH-1:0] cout_sh_q, cout_sh_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] coutw_q, coutw_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic [1:0]       opcode_q, opcode_d;

  // Accumulators shifted right with the new bit entering at the MSB, so after
  // WIDTH shifts bit i holds the alu output for operand bit i.
  logic [WIDTH-1:0] res_nxt, cout_nxt;
  assign res_nxt  = (res_sh_q  >> 1) | {alu_result, {(WIDTH-1){1'b0}}};
  assign cout_nxt = (cout_sh_q >> 1) | {alu_cout,   {(WIDTH-1){1'b0}}};

  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    res_sh_d  = res_sh_q;
    cout_sh_d = cout_sh_q;
    result_d  = result_q;
    coutw_d   = coutw_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    opcode_d  = opcode_q;
    case (state_q)
      SHIFT: begin
        a_sh_d    = a_sh_q >> 1;
        b_sh_d    = b_sh_q >> 1;
        res_sh_d  = res_nxt;
        cout_sh_d = cout_nxt;
        cnt_d     = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d  = DONE;
          result_d = res_nxt;
          coutw_d  = cout_nxt;
        end
      end
      default: begin
        // IDLE and DONE both accept a new request; DONE otherwise drops to IDLE.
        if (state_q == DONE) state_d = IDLE;
        if (start) begin
          state_d   = SHIFT;
          a_sh_d    = a_in;
          b_sh_d    = b_in;
          mode_d    = mode_in;
          opcode_d  = opcode_in;
          cnt_d     = '0;
          res_sh_d  = '0;
          cout_sh_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      res_sh_q  <= '0;
      cout_sh_q <= '0;
      result_q  <= '0;
      coutw_q   <= '0;
      cnt_q     <= '0;
      mode_q    <= '0;
      opcode_q  <= '0;
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      res_sh_q  <= res_sh_d;
      cout_sh_q <= cout_sh_d;
      result_q  <= result_d;
      coutw_q   <= coutw_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      opcode_q  <= opcode_d;
    end
  end

  always_comb begin
    busy       = (state_q == SHIFT);
    done       = (state_q == DONE);
    alu_mode   = busy ? mode_q   : '0;
    alu_opcode = busy ? opcode_q : '0;
    alu_ain    = busy & a_sh_q[0];
    alu_bin    = busy & b_sh_q[0];
    result_out = result_q;
    cout_out   = coutw_q;
  end

endmodule

// File: tb/tb_alu_serial_seq.sv
module tb_alu_serial_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   mode_in, opcode_in;
  logic [W-1:0] a_in, b_in;
  logic         busy, done;
  logic [W-1:0] result_out, cout_out;
  logic [1:0]   alu_mode, alu_opcode;
  logic         alu_ain, alu_bin;
  logic         alu_result, alu_cout;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // alu stand-in
  assign alu_result = alu_ain ^ alu_bin;
  assign alu_cout   = alu_ain & alu_bin;

  alu_serial_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .mode_in(mode_in), .opcode_in(opcode_in),
    .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done),
    .result_out(result_out), .cout_out(cout_out),
    .alu_mode(alu_mode), .alu_opcode(alu_opcode),
    .alu_ain(alu_ain), .alu_bin(alu_bin),
    .alu_result(alu_result), .alu_cout(alu_cout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One full operation: accept, WIDTH busy cycles checked bit by bit, then done.
  // inject > 0 pulses start with junk operands during that busy cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [1:0] md, input logic [1:0] op, input int inject);
    @(posedge clk); #1;
    start = 1'b1; a_in = a; b_in = b; mode_in = md; opcode_in = op;
    @(posedge clk); #1;
    start = 1'b0;
    a_in = W'($urandom); b_in = W'($urandom);
    mode_in = 2'($urandom); opcode_in = 2'($urandom);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      check("busy", busy, 1);
      check("done_in_shift", done, 0);
      check("ain", alu_ain, a[i]);
      check("bin", alu_bin, b[i]);
      check("mode_shift", alu_mode, md);
      check("opcode_shift", alu_opcode, op);
      if (i + 1 == inject) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    @(negedge clk);
    check("done", done, 1);
    check("busy_in_done", busy, 0);
    check("result", result_out, a ^ b);
    check("cout", cout_out, a & b);
    check("mode_idle", alu_mode, 0);
    check("opcode_idle", alu_opcode, 0);
    check("ain_idle", alu_ain, 0);
  endtask

  initial begin
    int last_done, n_done;
    logic [W-1:0] exp_r [2];
    logic [W-1:0] exp_c [2];

    reset = 1'b1; start = 1'b0; mode_in = '0; opcode_in = '0; a_in = '0; b_in = '0;
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result_out, 0);
    check("rst_cout", cout_out, 0);
    check("rst_mode", alu_mode, 0);
    @(negedge clk); reset = 1'b0;

    // basic op, then with mode/opcode, then a start pulse while busy
    run_op(8'hA5, 8'h0F, 2'b00, 2'b00, 0);
    run_op(8'hA5, 8'h0F, 2'b10, 2'b01, 0);
    run_op(8'h3C, 8'h96, 2'b01, 2'b11, 3);

    // start held high: done pulses WIDTH+1 apart, second op takes the new operands
    @(posedge clk); #1;
    start = 1'b1; a_in = 8'hFF; b_in = 8'hFF;
    exp_r[0] = 8'h00; exp_c[0] = 8'hFF;
    exp_r[1] = 8'h01; exp_c[1] = 8'h00;
    @(posedge clk); #1;
    a_in = 8'h00; b_in = 8'h01;
    n_done = 0; last_done = 0;
    for (int cyc = 1; cyc <= 30 && n_done < 2; cyc++) begin
      @(negedge clk);
      if (done) begin
        check("held_result", result_out, exp_r[n_done]);
        check("held_cout", cout_out, exp_c[n_done]);
        if (n_done == 1) check("held_spacing", cyc - last_done, W + 1);
        last_done = cyc;
        n_done++;
      end
    end
    check("held_done_count", n_done, 2);
    @(posedge clk); #1; start = 1'b0;
    repeat (W + 2) @(posedge clk);

    // reset during busy cycle 4 aborts with no done
    @(posedge clk); #1;
    start = 1'b1; a_in = 8'h5A; b_in = 8'hC3;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre_abort_busy", busy, 1);
    reset = 1'b1; #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result", result_out, 0);
    check("abort_cout", cout_out, 0);
    check("abort_mode", alu_mode, 0);
    check("abort_ain", alu_ain, 0);
    @(posedge clk); #1; reset = 1'b0;
    n_done = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("abort_no_done", n_done, 0);
    run_op(8'hA5, 8'h0F, 2'b00, 2'b00, 0);

    // randomized operations
    for (int k = 0; k < 20; k++)
      run_op(W'($urandom), W'($urandom), 2'($urandom), 2'($urandom),
             int'($urandom_range(0, W)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
